// File: rtl/tbb_bus_pkg.sv
// Shared constants, op encoding, FSM states and nibble helpers
// for the TBB1143 bus writer.
package tbb_bus_pkg;

    localparam logic [2:0] TBB_ADDR_CH0_L  = 3'd1;
    localparam logic [2:0] TBB_ADDR_CH0_H  = 3'd2;
    localparam logic [2:0] TBB_ADDR_CH0_HH = 3'd3;
    localparam logic [2:0] TBB_ADDR_CH1_L  = 3'd4;
    localparam logic [2:0] TBB_ADDR_CH1_H  = 3'd5;
    localparam logic [2:0] TBB_ADDR_CH1_HH = 3'd6;
    localparam logic [2:0] TBB_ADDR_OUTEN  = 3'd7;

    localparam logic TBB_OP_TONE = 1'b0;
    localparam logic TBB_OP_EN   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        GAP,
        DONE
    } tbb_state_e;

    function automatic logic [2:0] tbb_addr(
        input logic       op,
        input logic       ch,
        input logic [1:0] idx
    );
        if (op == TBB_OP_EN)
            return TBB_ADDR_OUTEN;
        return (ch ? TBB_ADDR_CH1_L : TBB_ADDR_CH0_L) + {1'b0, idx};
    endfunction

    function automatic logic [3:0] tbb_nib(
        input logic        op,
        input logic [11:0] data,
        input logic [1:0]  idx
    );
        if (op == TBB_OP_EN)
            return {2'b00, data[1:0]};
        case (idx)
            2'd0:    return data[3:0];
            2'd1:    return data[7:4];
            default: return data[11:8];
        endcase
    endfunction

    function automatic logic [1:0] tbb_first(input logic [2:0] m);
        if (m[0]) return 2'd0;
        if (m[1]) return 2'd1;
        return 2'd2;
    endfunction

endpackage

// File: rtl/tbb_shadow_regs.sv
// Shadow copy of chip registers 1..7 (value + valid) with
// three parallel compare lookups for skip-unchanged writes.
module tbb_shadow_regs
    import tbb_bus_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            we_i,
    input  logic [2:0]      waddr_i,
    input  logic [3:0]      wdata_i,
    input  logic [2:0][2:0] caddr_i,
    input  logic [2:0][3:0] cdata_i,
    output logic [2:0]      hit_o
);

    logic [7:0]      vld_q;
    logic [7:0][3:0] val_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_q <= '0;
            val_q <= '0;
        end else if (we_i) begin
            vld_q[waddr_i] <= 1'b1;
            val_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        hit_o = '0;
        for (int i = 0; i < 3; i++)
            hit_o[i] = vld_q[caddr_i[i]] &&
                       (val_q[caddr_i[i]] == cdata_i[i]);
    end

endmodule

// File: rtl/tbb_bus_writer.sv
// TBB1143 bus-write initiator: turns tone/enable commands into
// addr+data write pairs. TBB_SKIP_UNCHANGED_EN skips unchanged nibbles.
module tbb_bus_writer
    import tbb_bus_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic        cmd_ch,
    input  logic [11:0] cmd_data,
    output logic        cmd_done,
    output logic        WR,
    output logic        A0,
    output logic [3:0]  D
);

    localparam bit NO_GAP = (GAP_CYCLES == 0);
    localparam logic [2:0] GAP_RLD =
        (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

    tbb_state_e  state_q, state_d;
    logic        op_q, op_d;
    logic        ch_q, ch_d;
    logic [11:0] data_q, data_d;
    logic [2:0]  pend_q, pend_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  gcnt_q, gcnt_d;
    logic        phase_q, phase_d;
    logic        wr_q, wr_d;
    logic        a0_q, a0_d;
    logic [3:0]  d_q, d_d;
    logic        done_q, done_d;
    logic [2:0]  base_mask;
    logic [2:0]  pend_acc;

    assign base_mask = (cmd_op == TBB_OP_EN) ? 3'b001 : 3'b111;

`ifdef TBB_SKIP_UNCHANGED_EN
    logic [2:0]      hit;
    logic [2:0][2:0] caddr;
    logic [2:0][3:0] cdata;

    always_comb begin
        caddr = '0;
        cdata = '0;
        for (int i = 0; i < 3; i++) begin
            caddr[i] = tbb_addr(cmd_op, cmd_ch, 2'(i));
            cdata[i] = tbb_nib(cmd_op, cmd_data, 2'(i));
        end
    end

    tbb_shadow_regs u_shadow (
        .CLK     (CLK),
        .RST     (RST),
        .we_i    (state_q == DATA),
        .waddr_i (tbb_addr(op_q, ch_q, idx_q)),
        .wdata_i (tbb_nib(op_q, data_q, idx_q)),
        .caddr_i (caddr),
        .cdata_i (cdata),
        .hit_o   (hit)
    );

    assign pend_acc = base_mask & ~hit;
`else
    assign pend_acc = base_mask;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ch_d    = ch_q;
        data_d  = data_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    ch_d    = cmd_ch;
                    data_d  = cmd_data;
                    pend_d  = pend_acc;
                    idx_d   = tbb_first(pend_acc);
                    state_d = (pend_acc == 3'b000) ? DONE : ADDR;
                end
            end
            ADDR: begin
                phase_d = 1'b1;
                gcnt_d  = GAP_RLD;
                state_d = NO_GAP ? DATA : GAP;
            end
            DATA: begin
                pend_d  = pend_q & ~(3'b001 << idx_q);
                idx_d   = tbb_first(pend_d);
                phase_d = 1'b0;
                gcnt_d  = GAP_RLD;
                if (pend_d == 3'b000)
                    state_d = DONE;
                else
                    state_d = NO_GAP ? ADDR : GAP;
            end
            GAP: begin
                if (gcnt_q == 3'd0)
                    state_d = phase_q ? DATA : ADDR;
                else
                    gcnt_d = gcnt_q - 3'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus pins are registered from the next state so WR tracks ADDR/DATA.
    always_comb begin
        wr_d   = (state_d == ADDR) || (state_d == DATA);
        a0_d   = (state_d == DATA);
        done_d = (state_d == DONE);
        d_d    = 4'd0;
        if (state_d == ADDR)
            d_d = {1'b0, tbb_addr(op_d, ch_d, idx_d)};
        else if (state_d == DATA)
            d_d = tbb_nib(op_d, data_d, idx_d);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            ch_q    <= 1'b0;
            data_q  <= '0;
            pend_q  <= '0;
            idx_q   <= '0;
            gcnt_q  <= '0;
            phase_q <= 1'b0;
            wr_q    <= 1'b0;
            a0_q    <= 1'b0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            phase_q <= phase_d;
            wr_q    <= wr_d;
            a0_q    <= a0_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign cmd_done  = done_q;
    assign WR        = wr_q;
    assign A0        = a0_q;
    assign D         = d_q;

endmodule
